// File: rtl/wb_reg_pkg.sv
// wb_reg_pkg: shared FSM states and register-index offsets for wb_reg_slave
package wb_reg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TERM} state_t;
  localparam int INT_STATUS_OFS = 2;
  localparam int INT_ENABLE_OFS = 1;
endpackage

// File: rtl/wb_wait_ctr.sv
// wb_wait_ctr: loadable wait-state down-counter, saturating at zero
module wb_wait_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          en,
  input  logic [CW-1:0] d,
  output logic [CW-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : ld ? d : (en && q != '0) ? q - 1'b1 : q;
endmodule

// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone register slave with scratch words, W1C interrupt status and enable
module wb_reg_slave
  import wb_reg_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREGS = 8,
  parameter int WAIT  = 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_int_o,
  input  logic [DW-1:0]   event_i
);
  localparam int IW = AW - 2;
  localparam int RW = $clog2(NREGS);
  localparam int SI = NREGS - INT_STATUS_OFS;
  localparam int EI = NREGS - INT_ENABLE_OFS;
  state_t state, state_nxt;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q, mask;
  logic [DW/8-1:0] sel_q;
  logic we_q, err_q, req, ld, bad, term, wr;
  logic [IW-1:0] idx;
  logic [3:0] cnt;
  logic [DW-1:0] regs [NREGS];
  assign idx  = adr_q[AW-1:2];
  assign req  = wb_cyc_i & wb_stb_i;
  assign ld   = state == ST_IDLE && req;
  assign bad  = 32'(wb_adr_i[AW-1:2]) >= 32'(NREGS) || wb_adr_i[1:0] != 2'b00 || wb_sel_i == '0;
  assign term = state == ST_TERM && wb_cyc_i;
  assign wb_ack_o = term & ~err_q;
  assign wb_err_o = term & err_q;
  assign wr = wb_ack_o & we_q;
  assign wb_dat_o = (wb_ack_o && !we_q) ? regs[idx[RW-1:0]] : '0;
  for (genvar b = 0; b < DW/8; b++) assign mask[8*b +: 8] = {8{sel_q[b]}};
  wb_wait_ctr #(.CW(4)) u_ctr (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .ld (ld),
    .en (state == ST_WAIT),
    .d  (4'(WAIT)),
    .q  (cnt)
  );
  always_comb begin
    state_nxt = state == ST_IDLE ? (req ? (WAIT == 0 ? ST_TERM : ST_WAIT) : ST_IDLE)
              : state == ST_WAIT ? (!wb_cyc_i ? ST_IDLE : cnt == 4'd1 ? ST_TERM : ST_WAIT)
              : ST_IDLE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld) begin
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        we_q  <= wb_we_i;
        err_q <= bad;
      end
    end
  end
  // event pulses are ORed in after the W1C clear so a coincident set wins
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wb_int_o <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (i == SI) regs[i] <= (regs[i] & ~((wr && idx == IW'(SI)) ? dat_q & mask : '0)) | event_i;
        else if (wr && idx == IW'(i)) regs[i] <= (regs[i] & ~mask) | (dat_q & mask);
      wb_int_o <= |(regs[SI] & regs[EI]);
    end
  end
endmodule

// File: tb/tb_wb_reg_slave.sv
// tb_wb_reg_slave: directed Wishbone transfers checked against a per-instance behavioural model
module tb_wb_reg_slave;
  localparam int DW = 32, AW = 6, NREGS = 8;
  localparam logic [AW-1:0] A_STAT = AW'((NREGS-2)*4), A_EN = AW'((NREGS-1)*4);
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat, ev;
  logic [3:0] sel;
  logic we, stb;
  logic [1:0] cyc, ack, err, irq;
  logic [DW-1:0] dato [2];
  int pass = 0, total = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic bad(logic [AW-1:0] a, logic [3:0] s);
    return int'(a[AW-1:2]) >= NREGS || a[1:0] != 2'b00 || s == 4'h0;
  endfunction
  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int WT = k ? 3 : 1;
    logic [DW-1:0] m_reg [NREGS];
    logic m_busy = 0, m_int = 0, m_we;
    int m_age;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    logic [3:0] m_sel;
    wb_reg_slave #(.DW(DW), .AW(AW), .NREGS(NREGS), .WAIT(WT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dato[k]),
      .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc[k]), .wb_ack_o(ack[k]),
      .wb_err_o(err[k]), .wb_int_o(irq[k]), .event_i(ev));
    always @(posedge clk) begin
      logic [DW-1:0] msk;
      logic nint;
      int i;
      if (rst) begin
        foreach (m_reg[j]) m_reg[j] = '0;
        m_busy = 0;
        m_int = 0;
      end else begin
        nint = |(m_reg[NREGS-2] & m_reg[NREGS-1]);
        msk = {{8{m_sel[3]}}, {8{m_sel[2]}}, {8{m_sel[1]}}, {8{m_sel[0]}}};
        if (m_busy) begin
          if (!cyc[k]) m_busy = 0;
          else if (m_age == WT + 1) begin
            if (m_we && !bad(m_adr, m_sel)) begin
              i = int'(m_adr[AW-1:2]);
              if (i == NREGS - 2) m_reg[i] = m_reg[i] & ~(m_dat & msk);
              else m_reg[i] = (m_reg[i] & ~msk) | (m_dat & msk);
            end
            m_busy = 0;
          end else m_age++;
        end else if (stb && cyc[k]) begin
          m_busy = 1;
          m_age = 1;
          m_adr = adr;
          m_dat = dat;
          m_sel = sel;
          m_we = we;
        end
        m_reg[NREGS-2] = m_reg[NREGS-2] | ev;
        m_int = nint;
      end
    end
    always @(negedge clk) begin
      logic t, a;
      logic [DW-1:0] d;
      t = m_busy && m_age == WT + 1 && cyc[k];
      a = t && !bad(m_adr, m_sel);
      d = (a && !m_we) ? m_reg[int'(m_adr[AW-1:2])] : '0;
      chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(a));
      chk($sformatf("err%0d", k), 32'(err[k]), 32'(t && !a));
      chk($sformatf("dat%0d", k), dato[k], d);
      chk($sformatf("int%0d", k), 32'(irq[k]), 32'(m_int));
    end
  end
  task automatic xfer(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                      input logic w, output logic [DW-1:0] rd, output logic ga, output logic ge, output int lat);
    adr = a; dat = d; sel = s; we = w; stb = 1; cyc[k] = 1;
    rd = '0; ga = 0; ge = 0; lat = 0;
    @(posedge clk);
    for (int n = 1; n <= 20 && !(ga || ge); n++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        ga = ack[k]; ge = err[k]; rd = dato[k]; lat = n;
      end
    end
    if (!(ga || ge)) chk("timeout", 0, 1);
    @(posedge clk);
    #1 stb = 0; cyc[k] = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] rd;
    logic ga, ge;
    int lat;
    cyc = 0; stb = 0; adr = 0; dat = 0; sel = 0; we = 0; ev = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ack", 32'(ack[0]), 0);
    chk("rst_int", 32'(irq[0]), 0);
    @(posedge clk); #1;
    xfer(0, 'h04, 32'hDEADBEEF, 4'hF, 1, rd, ga, ge, lat);
    chk("wr_ack", 32'(ga), 1);
    chk("wr_lat", 32'(lat), 2);
    xfer(0, 'h04, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("rd_dat", rd, 32'hDEADBEEF);
    chk("rd_lat", 32'(lat), 2);
    xfer(0, 'h04, 32'h000000AA, 4'h1, 1, rd, ga, ge, lat);
    xfer(0, 'h04, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("byte_wr", rd, 32'hDEADBEAA);
    xfer(0, 'h20, 32'h12345678, 4'hF, 1, rd, ga, ge, lat);
    chk("err_idx", {30'd0, ga, ge}, 32'd1);
    xfer(0, 'h05, 32'h12345678, 4'hF, 1, rd, ga, ge, lat);
    chk("err_align", {30'd0, ga, ge}, 32'd1);
    xfer(0, 'h04, 32'h12345678, 4'h0, 1, rd, ga, ge, lat);
    chk("err_sel", {30'd0, ga, ge}, 32'd1);
    xfer(0, 'h04, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("err_nowr", rd, 32'hDEADBEAA);
    xfer(0, A_EN, 32'h4, 4'hF, 1, rd, ga, ge, lat);
    ev = 32'h4;
    @(posedge clk); #1 ev = 0;
    @(negedge clk);
    chk("int_lag", 32'(irq[0]), 0);
    @(negedge clk);
    chk("int_set", 32'(irq[0]), 1);
    @(posedge clk); #1;
    xfer(0, A_STAT, 32'h4, 4'hF, 1, rd, ga, ge, lat);
    @(posedge clk); #1;
    chk("int_clr", 32'(irq[0]), 0);
    xfer(0, A_STAT, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("stat_clr", rd, 32'h0);
    ev = 32'h4;
    xfer(0, A_STAT, 32'h4, 4'hF, 1, rd, ga, ge, lat);
    ev = 0;
    xfer(0, A_STAT, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("set_wins", rd, 32'h4);
    xfer(0, A_STAT, 32'h4, 4'hF, 1, rd, ga, ge, lat);
    xfer(1, 'h08, 32'h11111111, 4'hF, 1, rd, ga, ge, lat);
    chk("w3_lat", 32'(lat), 4);
    adr = 'h08; dat = 32'h22222222; sel = 4'hF; we = 1; stb = 1; cyc[1] = 1;
    repeat (2) @(posedge clk);
    #1 cyc[1] = 0; stb = 0;
    ga = 0;
    repeat (6) begin
      @(negedge clk);
      ga = ga | ack[1] | err[1];
    end
    chk("abort_term", 32'(ga), 0);
    @(posedge clk); #1;
    xfer(1, 'h08, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("abort_nowr", rd, 32'h11111111);
    chk("abort_next", {lat[29:0], ga, ge}, {30'd4, 2'b10});
    ev = 32'h1;
    @(posedge clk); #1 ev = 0;
    adr = 'h04; dat = 32'h5; sel = 4'hF; we = 1; stb = 1; cyc[0] = 1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; stb = 0; cyc[0] = 0;
    @(negedge clk);
    chk("rst_out", {28'd0, ack[0], err[0], irq[0], |dato[0]}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 'h04, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("rst_scr", rd, 32'h0);
    xfer(0, A_STAT, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("rst_stat", rd, 32'h0);
    xfer(0, A_EN, 0, 4'hF, 0, rd, ga, ge, lat);
    chk("rst_en", rd, 32'h0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/wb_reg_slave.md
WB_REG_SLAVE -- requirements
Module: wb_reg_slave

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width (multiple of 8).
REQ-002 SHALL have parameter AW, default 5, byte address width.
REQ-003 SHALL have parameter NREGS, default 8, number of 32-bit word registers (3..2**(AW-2)).
REQ-004 SHALL have parameter WAIT, default 1, wait states before termination (0..15).
REQ-005 SHALL have ports:
 - wb_clk_i  in  1  single clock, all logic on posedge
 - wb_rst_i  in  1  reset, synchronous, active-high
 - wb_adr_i  in  AW  byte address
 - wb_dat_i  in  DW  write data
 - wb_dat_o  out  DW  read data
 - wb_sel_i  in  DW/8  byte selects
 - wb_we_i  in  1  write enable
 - wb_stb_i  in  1  strobe
 - wb_cyc_i  in  1  valid bus cycle
 - wb_ack_o  out  1  normal termination
 - wb_err_o  out  1  error termination
 - wb_int_o  out  1  interrupt request
 - event_i  in  DW  hardware event pulses, one per status bit

Function
REQ-006 SHALL decode word index = wb_adr_i[AW-1:2]; indices 0..NREGS-3 are RW scratch, NREGS-2 is INT_STATUS (W1C), NREGS-1 is INT_ENABLE (RW).
REQ-007 SHALL implement FSM IDLE -> WAIT -> TERM -> IDLE; IDLE -> TERM directly when WAIT=0.
REQ-008 SHALL leave IDLE when wb_cyc_i & wb_stb_i, latching address, data, sel, we on that edge.
REQ-009 SHALL stay in WAIT for exactly WAIT cycles (down-counter), so termination appears WAIT+1 cycles after request sampling.
REQ-010 SHALL assert exactly one of wb_ack_o/wb_err_o for one cycle in TERM, then return to IDLE; a still-asserted stb in the following cycle starts a new transfer.
REQ-011 SHALL assert wb_err_o instead of wb_ack_o when index >= NREGS, wb_adr_i[1:0] != 0, or wb_sel_i == 0; errored writes SHALL not modify state.
REQ-012 SHALL perform writes on the TERM cycle, byte lanes gated by latched sel.
REQ-013 SHALL drive wb_dat_o with the addressed register during an ack'd read TERM cycle, and 0 in all other cycles.
REQ-014 SHALL abort to IDLE with no termination and no write if wb_cyc_i deasserts in WAIT or TERM.
REQ-015 SHALL set INT_STATUS bit n every cycle event_i[n]=1; a W1C write clearing the same bit in the same cycle SHALL lose (set wins).
REQ-016 SHALL drive wb_int_o registered: one cycle after |(INT_STATUS & INT_ENABLE) changes.

Reset
REQ-017 SHALL, while wb_rst_i=1 at a clock edge, return FSM to IDLE, clear counter, all registers, wb_dat_o, wb_ack_o, wb_err_o, wb_int_o to 0.
REQ-018 SHALL discard an in-flight transfer on reset with no termination; event_i ignored during reset.

Structure
REQ-019 SHALL place FSM state enum and register-index offset constants (INT_STATUS/INT_ENABLE relative to NREGS) in shared package wb_reg_pkg.
REQ-020 SHALL contain one sub-module, wb_wait_ctr, implementing the loadable wait-state down-counter.

Verification
REQ-021 WAIT=1: write 0xDEADBEEF to addr 0x04, sel=0xF -> ack 2 cycles after request; read 0x04 returns 0xDEADBEEF on ack.
REQ-022 Write 0x000000AA sel=0x1 over 0xDEADBEEF at 0x04 -> read back 0xDEADBEAA.
REQ-023 Access addr 0x20 (index 8, NREGS=8), addr 0x05, or sel=0 -> single-cycle wb_err_o, no ack, target unchanged.
REQ-024 event_i=0x4, INT_ENABLE=0x4 -> wb_int_o=1 one cycle after status set; W1C 0x4 -> wb_int_o=0 one cycle after ack; W1C coincident with event_i[2] -> bit stays 1.
REQ-025 WAIT=3: drop wb_cyc_i in 2nd wait cycle of write -> no ack/err, register unchanged; next transfer terminates normally.
REQ-026 Assert wb_rst_i during WAIT -> next cycle all outputs 0, FSM IDLE, scratch and INT registers read 0.
